imem_arbiter: RTL and testbench

//  Shares the single-port instruction RAM between the fetch stage (read every cycle) and a program loader/debug master.

---
 rtl/definitions_pkg.sv | 24 ++
 rtl/imem_arb_perf.sv | 35 +++
 rtl/imem_arbiter.sv | 129 ++++++++++++
 tb/tb_imem_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/definitions_pkg.sv
// Shared types for the instruction-memory arbiter: word types, FSM states and
// a saturating-increment helper used by the optional perf counters.
package definitions_pkg;

    localparam int unsigned IMEM_ADDR_W = 32;
    localparam int unsigned IMEM_DATA_W = 32;
    localparam int unsigned PERF_CNT_W  = 32;

    typedef logic [IMEM_ADDR_W-1:0] imem_addr_t;
    typedef logic [IMEM_DATA_W-1:0] imem_data_t;
    typedef logic [PERF_CNT_W-1:0]  perf_cnt_t;

    typedef enum logic [1:0] {
        ARB_BOOT,
        ARB_RUN,
        ARB_LOAD,
        ARB_FLUSH
    } imem_arb_state_e;

    function automatic perf_cnt_t sat_inc(input perf_cnt_t value, input logic en);
        return (en && (value != '1)) ? value + 1'b1 : value;
    endfunction

endpackage

// File: rtl/imem_arb_perf.sv
// Two saturating event counters for the arbiter: stalled fetch cycles outside
// BOOT and loader grants. Only instantiated when IMEM_ARB_PERF_EN is defined.
module imem_arb_perf
    import definitions_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      stall_evt_i,
    input  logic      gnt_evt_i,
    output perf_cnt_t perf_stall_cnt_o,
    output perf_cnt_t perf_ld_cnt_o
);

    perf_cnt_t stall_cnt_q, stall_cnt_d;
    perf_cnt_t ld_cnt_q,    ld_cnt_d;

    always_comb begin
        stall_cnt_d = sat_inc(stall_cnt_q, stall_evt_i);
        ld_cnt_d    = sat_inc(ld_cnt_q, gnt_evt_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            ld_cnt_q    <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            ld_cnt_q    <= ld_cnt_d;
        end
    end

    assign perf_stall_cnt_o = stall_cnt_q;
    assign perf_ld_cnt_o    = ld_cnt_q;

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction RAM arbiter between fetch and the loader/debug master.
// Optional perf counters are enabled with the IMEM_ARB_PERF_EN macro.
module imem_arbiter
    import definitions_pkg::*;
#(
    parameter int unsigned ADDR_W    = IMEM_ADDR_W,
    parameter int unsigned DATA_W    = IMEM_DATA_W,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              boot_done_i,
    input  logic [ADDR_W-1:0] ft_addr_i,
    output logic [DATA_W-1:0] ft_instr_o,
    output logic              ft_stall_o,
    output logic              ft_flush_o,
    input  logic              ld_req_i,
    input  logic              ld_we_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [DATA_W-1:0] ld_wdata_i,
    output logic              ld_gnt_o,
    output logic              ld_rvalid_o,
    output logic [DATA_W-1:0] ld_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
`ifdef IMEM_ARB_PERF_EN
    ,
    output perf_cnt_t         perf_stall_cnt_o,
    output perf_cnt_t         perf_ld_cnt_o
`endif
);

    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);

    imem_arb_state_e   state_q, state_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic              dirty_q, dirty_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ld_owns;
    logic              ld_gnt_raw;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        dirty_d     = dirty_q;
        ld_owns     = 1'b0;
        ld_gnt_raw  = 1'b0;
        ft_stall_o  = 1'b1;
        ft_flush_o  = 1'b0;

        case (state_q)
            ARB_BOOT: begin
                ld_owns    = 1'b1;
                ld_gnt_raw = ld_req_i;
                dirty_d    = dirty_q | (ld_req_i & ld_we_i);
                if (boot_done_i) state_d = ARB_FLUSH;
            end
            ARB_RUN: begin
                ft_stall_o = 1'b0;
                if (ld_req_i) state_d = ARB_LOAD;
            end
            ARB_LOAD: begin
                ld_owns    = 1'b1;
                ld_gnt_raw = ld_req_i;
                dirty_d    = dirty_q | (ld_req_i & ld_we_i);
                if (ld_req_i) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                    // Force fetch back once the burst budget is spent.
                    if (burst_cnt_q == BURST_W'(MAX_BURST - 1)) state_d = ARB_FLUSH;
                end else begin
                    state_d = ARB_FLUSH;
                end
            end
            ARB_FLUSH: begin
                ft_flush_o  = dirty_q;
                burst_cnt_d = '0;
                dirty_d     = 1'b0;
                state_d     = ARB_RUN;
            end
            default: state_d = ARB_BOOT;
        endcase

        // Reset is asynchronous, so the grant is masked combinationally too.
        ld_gnt_o = ld_gnt_raw & rst_ni;
        rvalid_d = ld_gnt_o & ~ld_we_i;
        rdata_d  = rvalid_d ? mem_rdata_i : rdata_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    // NOTE: rdata is reset because it is a visible port value; RAM contents themselves are never reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ARB_BOOT;
            burst_cnt_q <= '0;
            dirty_q     <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            dirty_q     <= dirty_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
        end
    end

    assign mem_addr_o  = ld_owns ? ld_addr_i : ft_addr_i;
    assign mem_we_o    = ld_gnt_o & ld_we_i;
    assign mem_wdata_o = ld_wdata_i;
    assign ft_instr_o  = mem_rdata_i;
    assign ld_rvalid_o = rvalid_q;
    assign ld_rdata_o  = rdata_q;

`ifdef IMEM_ARB_PERF_EN
    imem_arb_perf u_perf (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .stall_evt_i      (ft_stall_o && (state_q != ARB_BOOT)),
        .gnt_evt_i        (ld_gnt_o),
        .perf_stall_cnt_o (perf_stall_cnt_o),
        .perf_ld_cnt_o    (perf_ld_cnt_o)
    );
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a small behavioural RAM model.
// Perf counter checks are compiled in when IMEM_ARB_PERF_EN is defined.
module tb_imem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        boot_done;
    logic [31:0] ft_addr;
    logic [31:0] ft_instr;
    logic        ft_stall;
    logic        ft_flush;
    logic        ld_req;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_gnt;
    logic        ld_rvalid;
    logic [31:0] ld_rdata;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef IMEM_ARB_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_ld_cnt;
    logic [31:0] stall_base;
    logic [31:0] ld_base;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] ram [0:15];

    imem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .boot_done_i (boot_done),
        .ft_addr_i   (ft_addr),
        .ft_instr_o  (ft_instr),
        .ft_stall_o  (ft_stall),
        .ft_flush_o  (ft_flush),
        .ld_req_i    (ld_req),
        .ld_we_i     (ld_we),
        .ld_addr_i   (ld_addr),
        .ld_wdata_i  (ld_wdata),
        .ld_gnt_o    (ld_gnt),
        .ld_rvalid_o (ld_rvalid),
        .ld_rdata_o  (ld_rdata),
        .mem_addr_o  (mem_addr),
        .mem_we_o    (mem_we),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
`ifdef IMEM_ARB_PERF_EN
        ,
        .perf_stall_cnt_o (perf_stall_cnt),
        .perf_ld_cnt_o    (perf_ld_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr[5:2]];
    always @(posedge clk) if (mem_we) ram[mem_addr[5:2]] <= mem_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 32'h0;
        rst_n     = 1'b0;
        boot_done = 1'b0;
        ft_addr   = 32'h4;
        ld_req    = 1'b1;
        ld_we     = 1'b1;
        ld_addr   = 32'h0;
        ld_wdata  = 32'h1111_1111;

        // Reset held with a write requested
        tick();
        tick();
        #1;
        check("rst_gnt",    {31'b0, ld_gnt},    32'd0);
        check("rst_we",     {31'b0, mem_we},    32'd0);
        check("rst_stall",  {31'b0, ft_stall},  32'd1);
        check("rst_flush",  {31'b0, ft_flush},  32'd0);
        check("rst_rvalid", {31'b0, ld_rvalid}, 32'd0);
        check("rst_rdata",  ld_rdata,           32'd0);

        // Scenario 1: three boot writes, then boot_done
        rst_n = 1'b1;
        #1;
        check("boot_gnt0",  {31'b0, ld_gnt},   32'd1);
        check("boot_we0",   {31'b0, mem_we},   32'd1);
        check("boot_addr0", mem_addr,          32'h0);
        check("boot_stall", {31'b0, ft_stall}, 32'd1);
        tick();
        ld_addr = 32'h4; ld_wdata = 32'hDEAD_BEEF;
        #1;
        check("boot_gnt1", {31'b0, ld_gnt}, 32'd1);
        tick();
        ld_addr = 32'h8; ld_wdata = 32'h3333_3333;
        #1;
        check("boot_gnt2", {31'b0, ld_gnt}, 32'd1);
        tick();
        ld_req = 1'b0; boot_done = 1'b1;
        #1;
        check("boot_done_stall", {31'b0, ft_stall}, 32'd1);
        tick();
        boot_done = 1'b0;
        #1;
        check("flush1_stall", {31'b0, ft_stall}, 32'd1);
        check("flush1_flush", {31'b0, ft_flush}, 32'd1);
        check("flush1_addr",  mem_addr,          32'h4);
        tick();
        #1;
        check("run1_stall", {31'b0, ft_stall}, 32'd0);
        check("run1_flush", {31'b0, ft_flush}, 32'd0);
        check("run1_instr", ft_instr,          32'hDEAD_BEEF);

        // Scenario 2: loader holds request through a full burst
`ifdef IMEM_ARB_PERF_EN
        stall_base = perf_stall_cnt;
        ld_base    = perf_ld_cnt;
`endif
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h10; ld_wdata = 32'hA000_0000;
        #1;
        check("run_req_gnt",   {31'b0, ld_gnt},   32'd0);
        check("run_req_stall", {31'b0, ft_stall}, 32'd0);
        check("run_req_addr",  mem_addr,          32'h4);
        tick();
        for (int i = 0; i < 8; i++) begin
            ld_addr  = 32'h10 + 32'(4 * i);
            ld_wdata = 32'hA000_0000 + 32'(i);
            #1;
            check($sformatf("burst_gnt%0d", i),   {31'b0, ld_gnt},   32'd1);
            check($sformatf("burst_stall%0d", i), {31'b0, ft_stall}, 32'd1);
            tick();
        end
        #1;
        check("burst_flush_gnt",   {31'b0, ld_gnt},   32'd0);
        check("burst_flush_stall", {31'b0, ft_stall}, 32'd1);
        check("burst_flush_flush", {31'b0, ft_flush}, 32'd1);
        tick();
        #1;
        check("burst_run_gnt",   {31'b0, ld_gnt},   32'd0);
        check("burst_run_stall", {31'b0, ft_stall}, 32'd0);
`ifdef IMEM_ARB_PERF_EN
        check("perf_ld",    perf_ld_cnt - ld_base,       32'd8);
        check("perf_stall", perf_stall_cnt - stall_base, 32'd9);
`endif
        tick();
        ld_addr = 32'h30; ld_wdata = 32'hB0B0_B0B0;
        #1;
        check("reload_gnt", {31'b0, ld_gnt}, 32'd1);
        check("ram_burst7", ram[11],          32'hA000_0007);
        tick();
        ld_req = 1'b0;
        #1;
        check("reload_idle_gnt",   {31'b0, ld_gnt},   32'd0);
        check("reload_idle_stall", {31'b0, ft_stall}, 32'd1);
        tick();
        #1;
        check("reload_flush", {31'b0, ft_flush}, 32'd1);
        tick();

        // Scenario 3: read-only burst
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h4;
        tick();
        #1;
        check("rd_gnt",  {31'b0, ld_gnt}, 32'd1);
        check("rd_we",   {31'b0, mem_we}, 32'd0);
        check("rd_addr", mem_addr,        32'h4);
        tick();
        ld_req = 1'b0;
        #1;
        check("rd_rvalid", {31'b0, ld_rvalid}, 32'd1);
        check("rd_rdata",  ld_rdata,           32'hDEAD_BEEF);
        tick();
        #1;
        check("rd_flush_flush",  {31'b0, ft_flush},  32'd0);
        check("rd_flush_stall",  {31'b0, ft_stall},  32'd1);
        check("rd_flush_rvalid", {31'b0, ld_rvalid}, 32'd0);
        check("rd_flush_rdata",  ld_rdata,           32'hDEAD_BEEF);
        tick();

        // Scenario 5: reset asserted mid-LOAD with a write requested
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h3C; ld_wdata = 32'hCAFE_F00D;
        tick();
        #1;
        check("midload_gnt", {31'b0, ld_gnt}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_gnt",   {31'b0, ld_gnt},   32'd0);
        check("async_we",    {31'b0, mem_we},   32'd0);
        check("async_stall", {31'b0, ft_stall}, 32'd1);
        check("async_flush", {31'b0, ft_flush}, 32'd0);
        ld_req = 1'b0;
        tick();
        check("async_no_commit", ram[15], 32'h0);
        rst_n = 1'b1;
        tick();
        tick();
        #1;
        check("post_rst_stall", {31'b0, ft_stall}, 32'd1);
        check("post_rst_gnt",   {31'b0, ld_gnt},   32'd0);

        // Scenario 4: write and boot_done in the same BOOT cycle
        ft_addr = 32'h8;
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h8; ld_wdata = 32'h4444_4444; boot_done = 1'b1;
        #1;
        check("bd_gnt", {31'b0, ld_gnt}, 32'd1);
        check("bd_we",  {31'b0, mem_we}, 32'd1);
        tick();
        ld_req = 1'b0; boot_done = 1'b0;
        #1;
        check("bd_flush_flush", {31'b0, ft_flush}, 32'd1);
        check("bd_flush_stall", {31'b0, ft_stall}, 32'd1);
        check("bd_commit",      ft_instr,          32'h4444_4444);
        tick();
        #1;
        check("bd_run_stall", {31'b0, ft_stall}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
